uart_mmio_fifo: RTL and testbench

//  Memory-mapped UART and performance-counter interface, sitting between the pipeline's writeback stage and the UART core.

---
 rtl/uart_mmio_fifo.sv | 131 +++++++++++++
 tb/tb_uart_mmio_fifo.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/uart_mmio_fifo.sv
// Memory-mapped UART bridge: TX/RX byte FIFOs, sticky error flags and cycle/instruction counters.
// CPU-side side effects are gated by stall; the UART side runs every cycle.
module uart_mmio_fifo #(
   parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
   parameter int          TX_DEPTH  = 8,
   parameter int          RX_DEPTH  = 8,
   parameter int          CNT_WIDTH = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic [31:0] addr,
   input  logic        we,
   input  logic        re,
   input  logic [31:0] wdata,
   input  logic        retire,
   output logic        hit,
   output logic [31:0] rdata,
   output logic [7:0]  DataIn,
   output logic        DataInValid,
   input  logic        DataInReady,
   input  logic [7:0]  DataOut,
   input  logic        DataOutValid,
   output logic        DataOutReady
);
   localparam int TAW = $clog2(TX_DEPTH);
   localparam int RAW = $clog2(RX_DEPTH);

   logic [7:0]           r_tx_mem [TX_DEPTH];
   logic [TAW-1:0]       r_tx_wp, r_tx_rp;
   logic [TAW:0]         r_tx_cnt;
   logic [7:0]           r_rx_mem [RX_DEPTH];
   logic [RAW-1:0]       r_rx_wp, r_rx_rp;
   logic [RAW:0]         r_rx_cnt;
   logic                 r_tx_ovf, r_rx_unf;
   logic [CNT_WIDTH-1:0] r_cyc, r_ins;

   logic [31:0] w_off;
   logic [2:0]  w_idx;
   logic        w_wr, w_rd, w_tx_full, w_rx_empty;
   logic        w_tx_push, w_tx_pop, w_rx_push, w_rx_pop;
   logic        w_stat_wr, w_ovf_set, w_unf_set, w_cntrst;
   logic [TAW:0] w_tx_free;
   logic        w_unused;

   function automatic logic [7:0] sat8(input logic [31:0] v);
      return (v > 32'd255) ? 8'hFF : v[7:0];
   endfunction

   // Window is 0x20 bytes; the subtraction keeps unaligned BASE_ADDR values correct.
   assign w_off = addr - BASE_ADDR;
   assign hit   = (w_off[31:5] == 27'd0);
   assign w_idx = w_off[4:2];
   assign w_wr  = we & hit & ~stall;
   assign w_rd  = re & hit & ~stall;

   // Full/empty decisions for CPU accesses use pre-edge occupancy only.
   assign w_tx_full  = (r_tx_cnt == (TAW+1)'(TX_DEPTH));
   assign w_rx_empty = (r_rx_cnt == '0);
   assign w_tx_free  = (TAW+1)'(TX_DEPTH) - r_tx_cnt;

   assign w_tx_push = w_wr & (w_idx == 3'd2) & ~w_tx_full;
   assign w_tx_pop  = DataInValid & DataInReady;
   assign w_rx_push = DataOutValid & DataOutReady;
   assign w_rx_pop  = w_rd & (w_idx == 3'd1) & ~w_rx_empty;
   assign w_stat_wr = w_wr & (w_idx == 3'd0);
   assign w_ovf_set = w_wr & (w_idx == 3'd2) & w_tx_full;
   assign w_unf_set = w_rd & (w_idx == 3'd1) & w_rx_empty;
   assign w_cntrst  = w_wr & (w_idx == 3'd6);

   assign DataInValid  = (r_tx_cnt != '0);
   assign DataIn       = DataInValid ? r_tx_mem[r_tx_rp] : 8'h00;
   assign DataOutReady = (r_rx_cnt != (RAW+1)'(RX_DEPTH));

   assign w_unused = ^{wdata[31:8], w_off[1:0]};

   always_ff @(posedge clk) begin
      if (w_tx_push) r_tx_mem[r_tx_wp] <= wdata[7:0];
      if (w_rx_push) r_rx_mem[r_rx_wp] <= DataOut;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tx_wp  <= '0;
         r_tx_rp  <= '0;
         r_tx_cnt <= '0;
         r_rx_wp  <= '0;
         r_rx_rp  <= '0;
         r_rx_cnt <= '0;
         r_tx_ovf <= 1'b0;
         r_rx_unf <= 1'b0;
         r_cyc    <= '0;
         r_ins    <= '0;
      end else begin
         if (w_tx_push) r_tx_wp <= r_tx_wp + 1'b1;
         if (w_tx_pop)  r_tx_rp <= r_tx_rp + 1'b1;
         r_tx_cnt <= r_tx_cnt + (TAW+1)'(w_tx_push) - (TAW+1)'(w_tx_pop);
         if (w_rx_push) r_rx_wp <= r_rx_wp + 1'b1;
         if (w_rx_pop)  r_rx_rp <= r_rx_rp + 1'b1;
         r_rx_cnt <= r_rx_cnt + (RAW+1)'(w_rx_push) - (RAW+1)'(w_rx_pop);

         if (w_stat_wr)      r_tx_ovf <= 1'b0;
         else if (w_ovf_set) r_tx_ovf <= 1'b1;
         if (w_stat_wr)      r_rx_unf <= 1'b0;
         else if (w_unf_set) r_rx_unf <= 1'b1;

         // Counter clear outranks a same-cycle increment.
         if (w_cntrst) begin
            r_cyc <= '0;
            r_ins <= '0;
         end else begin
            r_cyc <= r_cyc + 1'b1;
            if (retire & ~stall) r_ins <= r_ins + 1'b1;
         end
      end
   end

   always_comb begin
      rdata = 32'd0;
      if (hit) begin
         case (w_idx)
            3'd0: rdata = {8'd0, sat8(32'(w_tx_free)), sat8(32'(r_rx_cnt)),
                           4'd0, r_rx_unf, r_tx_ovf, ~w_rx_empty, ~w_tx_full};
            3'd1: rdata = w_rx_empty ? 32'd0 : {24'd0, r_rx_mem[r_rx_rp]};
            3'd4: rdata = 32'(r_cyc);
            3'd5: rdata = 32'(r_ins);
            default: rdata = 32'd0;
         endcase
      end
   end
endmodule

// File: tb/tb_uart_mmio_fifo.sv
// Directed bench for uart_mmio_fifo: FIFO fill/drain, flags, stall gating, counters, reset.
module tb_uart_mmio_fifo;
   localparam logic [31:0] B = 32'h8000_0000;
   localparam logic [31:0] A_STAT = B + 32'h00, A_RX = B + 32'h04, A_TX = B + 32'h08;
   localparam logic [31:0] A_CYC = B + 32'h10, A_INS = B + 32'h14, A_CRST = B + 32'h18;

   logic        clk = 1'b0, rst = 1'b0, stall = 1'b0, we = 1'b0, re = 1'b0, retire = 1'b0;
   logic [31:0] addr = 32'd0, wdata = 32'd0;
   logic        hit;
   logic [31:0] rdata;
   logic [7:0]  DataIn, DataOut = 8'd0;
   logic        DataInValid, DataInReady = 1'b0, DataOutValid = 1'b0, DataOutReady;
   int total = 0, bad = 0;

   uart_mmio_fifo #(.BASE_ADDR(B), .TX_DEPTH(8), .RX_DEPTH(8), .CNT_WIDTH(4)) dut (
      .clk(clk), .rst(rst), .stall(stall), .addr(addr), .we(we), .re(re), .wdata(wdata),
      .retire(retire), .hit(hit), .rdata(rdata), .DataIn(DataIn), .DataInValid(DataInValid),
      .DataInReady(DataInReady), .DataOut(DataOut), .DataOutValid(DataOutValid),
      .DataOutReady(DataOutReady));

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
      addr = a;
      #1;
      chk(tag, rdata, exp);
   endtask

   initial begin
      // reset and counters (CNT_WIDTH=4)
      rst = 1'b1; tick(); tick(); rst = 1'b0;
      peek("rst_status", A_STAT, 32'h0008_0001);
      chk("rst_divalid", {31'd0, DataInValid}, 32'd0);
      chk("rst_doready", {31'd0, DataOutReady}, 32'd1);
      chk("rst_datain", {24'd0, DataIn}, 32'd0);
      peek("rst_cycles", A_CYC, 32'd0);
      chk("hit_in", {31'd0, hit}, 32'd1);
      addr = B + 32'h20; #1;
      chk("hit_out", {31'd0, hit}, 32'd0);
      repeat (17) tick();
      peek("cyc_wrap", A_CYC, 32'd1);
      retire = 1'b1; repeat (3) tick();
      peek("instrs3", A_INS, 32'd3);
      stall = 1'b1; repeat (2) tick(); stall = 1'b0;
      peek("instrs_stall", A_INS, 32'd3);
      addr = A_CRST; we = 1'b1; tick(); we = 1'b0; retire = 1'b0;
      peek("cntrst_ins", A_INS, 32'd0);
      peek("cntrst_cyc", A_CYC, 32'd0);
      tick();
      peek("cyc_after", A_CYC, 32'd1);

      // TX fill with overflow, then drain
      DataInReady = 1'b0;
      addr = A_TX; we = 1'b1;
      for (int i = 0; i < 9; i++) begin
         wdata = 32'h41 + i; tick();
      end
      we = 1'b0;
      peek("tx_full_stat", A_STAT, 32'h0000_0004);
      chk("tx_head", {24'd0, DataIn}, 32'h41);
      DataInReady = 1'b1;
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("tx_seq%0d", i), {23'd0, DataInValid, DataIn}, 32'h100 + 32'h41 + i);
         tick();
      end
      chk("tx_empty", {31'd0, DataInValid}, 32'd0);
      DataInReady = 1'b0;

      // RX fill, drain, underflow with same-cycle push
      DataOutValid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         DataOut = 8'h10 + 8'(i); tick();
      end
      DataOutValid = 1'b0;
      chk("rx_full_rdy", {31'd0, DataOutReady}, 32'd0);
      peek("rx_full_stat", A_STAT, 32'h0008_0807);
      addr = A_RX; re = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1; chk($sformatf("rx_seq%0d", i), rdata, 32'h10 + i);
         tick();
      end
      DataOutValid = 1'b1; DataOut = 8'h77;
      #1; chk("rx_unf_data", rdata, 32'd0);
      tick();
      re = 1'b0; DataOutValid = 1'b0;
      peek("rx_unf_stat", A_STAT, 32'h0008_010F);
      addr = A_RX; re = 1'b1; #1;
      chk("rx_kept", rdata, 32'h77);
      tick(); re = 1'b0;
      addr = A_STAT; we = 1'b1; tick(); we = 1'b0;
      peek("flags_clr", A_STAT, 32'h0008_0001);

      // stalled RX read pops exactly once
      DataOutValid = 1'b1;
      for (int i = 0; i < 8; i++) begin
         DataOut = 8'h10 + 8'(i); tick();
      end
      DataOutValid = 1'b0;
      addr = A_RX; re = 1'b1; stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         #1; chk($sformatf("stall_rd%0d", i), rdata, 32'h10);
         tick();
      end
      stall = 1'b0; #1;
      chk("unstall_rd", rdata, 32'h10);
      tick(); re = 1'b0;
      peek("after_pop", A_RX, 32'h11);
      peek("after_pop_stat", A_STAT, 32'h0008_0703);

      // TX write while full with same-cycle pop, then reset mid-burst
      addr = A_TX; we = 1'b1;
      for (int i = 0; i < 8; i++) begin
         wdata = 32'h50 + i; tick();
      end
      peek("tx_full2", A_STAT, 32'h0000_0702);
      addr = A_TX; wdata = 32'h99; DataInReady = 1'b1; #1;
      chk("pop_head", {24'd0, DataIn}, 32'h50);
      tick();
      we = 1'b0; DataInReady = 1'b0;
      peek("ovf_pop_stat", A_STAT, 32'h0001_0707);
      chk("next_head", {24'd0, DataIn}, 32'h51);
      DataInReady = 1'b1; DataOutValid = 1'b1; DataOut = 8'hAA; rst = 1'b1;
      tick();
      rst = 1'b0; DataInReady = 1'b0; DataOutValid = 1'b0;
      peek("midrst_stat", A_STAT, 32'h0008_0001);
      chk("midrst_divalid", {31'd0, DataInValid}, 32'd0);
      chk("midrst_datain", {24'd0, DataIn}, 32'd0);
      chk("midrst_doready", {31'd0, DataOutReady}, 32'd1);
      peek("midrst_cyc", A_CYC, 32'd0);
      peek("midrst_rx", A_RX, 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
